ctu_test_scan_seq: RTL and testbench

Scan-test sequencer in the CTU test stub, directly upstream of the per-cluster scan stub. Runs one scan load/unload pass on command:
- drives the stub's `global_shift_enable`, `ctu_tst_scan_disable` and `ctu_tst_short_chain` inputs;
- compacts the stub's returned `so_0` stream into a 16-bit MISR signature for the tester.

---
 rtl/ctu_test_scan_seq_if.sv | 25 ++
 rtl/ctu_test_scan_seq.sv | 96 +++++++++
 tb/tb_ctu_test_scan_seq.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctu_test_scan_seq_if.sv
// Tester-facing command/status bundle of the scan-test sequencer.
// The tester is the master; the sequencer is the slave.
interface ctu_test_scan_seq_if #(
    parameter int CNT_W = 16
);
    logic             scan_start;
    logic             scan_abort;
    logic [CNT_W-1:0] scan_len;
    logic             scan_short;
    logic             scan_capture_en;
    logic             scan_capture;
    logic             scan_busy;
    logic             scan_done;
    logic [15:0]      scan_sig;

    modport master (
        output scan_start, scan_abort, scan_len, scan_short, scan_capture_en,
        input  scan_capture, scan_busy, scan_done, scan_sig
    );

    modport slave (
        input  scan_start, scan_abort, scan_len, scan_short, scan_capture_en,
        output scan_capture, scan_busy, scan_done, scan_sig
    );
endinterface

// File: rtl/ctu_test_scan_seq.sv
// Scan-test sequencer: runs one load/unload pass into the cluster scan stub
// and compacts the returned so_0 stream into a 16-bit MISR signature.
//
//   state | meaning
//   IDLE  | waiting for an accepted start
//   SETUP | chain select settles one cycle ahead of shifting
//   SHIFT | shift enable high, one MISR sample per cycle
//   GAP   | one dead cycle after the last shift
//   CAPT  | one-cycle capture pulse (only if requested)
//   DONE  | one-cycle completion pulse, signature valid
module ctu_test_scan_seq #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ctu_test_scan_seq_if.slave   ctl,
    input  logic                 tst_scan_disable_req,
    input  logic                 so_0,
    output logic                 global_shift_enable,
    output logic                 ctu_tst_scan_disable,
    output logic                 ctu_tst_short_chain
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             cap_q;
    logic [15:0]      misr_nxt;

    assign misr_nxt = {ctl.scan_sig[14:0], 1'b0} ^
                      ((ctl.scan_sig[15] ^ so_0) ? 16'h1021 : 16'h0000);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (ctl.scan_start && !ctu_tst_scan_disable && !ctl.scan_abort)
                       nxt = SETUP;
            SETUP: nxt = (cnt != '0) ? SHIFT : GAP;
            SHIFT: if (cnt == '0) nxt = GAP;
            GAP:   nxt = cap_q ? CAPT : DONE;
            CAPT:  nxt = DONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (state != IDLE && ctl.scan_abort)
            nxt = IDLE;
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            cnt                  <= '0;
            cap_q                <= 1'b0;
            global_shift_enable  <= 1'b0;
            ctu_tst_scan_disable <= 1'b1;
            ctu_tst_short_chain  <= 1'b0;
            ctl.scan_capture     <= 1'b0;
            ctl.scan_busy        <= 1'b0;
            ctl.scan_done        <= 1'b0;
            ctl.scan_sig         <= 16'hFFFF;
        end else begin
            state                <= nxt;
            ctu_tst_scan_disable <= tst_scan_disable_req;
            global_shift_enable  <= (nxt == SHIFT);
            ctl.scan_capture     <= (nxt == CAPT);
            ctl.scan_done        <= (nxt == DONE);
            ctl.scan_busy        <= (nxt != IDLE);
            unique case (state)
                IDLE: if (nxt == SETUP) begin
                    cnt                 <= ctl.scan_len;
                    cap_q               <= ctl.scan_capture_en;
                    ctu_tst_short_chain <= ctl.scan_short;
                    ctl.scan_sig        <= 16'hFFFF;
                end
                // Loading len and decrementing here leaves len-1 for the first shift.
                SETUP: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                SHIFT: if (!ctl.scan_abort) begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    ctl.scan_sig <= misr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctu_test_scan_seq.sv
// Directed bench for the scan-test sequencer: cycle-by-cycle output checks per scenario.
module tb_ctu_test_scan_seq;

    logic clk = 1'b0;
    logic rst;
    logic tst_scan_disable_req;
    logic so_0;
    logic global_shift_enable;
    logic ctu_tst_scan_disable;
    logic ctu_tst_short_chain;

    int vectors     = 0;
    int miscompares = 0;

    ctu_test_scan_seq_if #(.CNT_W(16)) ctl ();

    ctu_test_scan_seq #(.CNT_W(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ctl                  (ctl),
        .tst_scan_disable_req (tst_scan_disable_req),
        .so_0                 (so_0),
        .global_shift_enable  (global_shift_enable),
        .ctu_tst_scan_disable (ctu_tst_scan_disable),
        .ctu_tst_short_chain  (ctu_tst_short_chain)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled on the edge inside this task; on return we sit in cycle t+1.
    task automatic start_pass(input logic [15:0] len, input logic sh, input logic cap);
        ctl.scan_len        = len;
        ctl.scan_short      = sh;
        ctl.scan_capture_en = cap;
        ctl.scan_start      = 1'b1;
        tick();
        ctl.scan_start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tst_scan_disable_req = 1'b0;
        tick();
        tick();
        vectors++;
        if (ctu_tst_scan_disable !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_disable got=%b exp=1", ctu_tst_scan_disable);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (ctu_tst_scan_disable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_disable_release got=%b exp=0", ctu_tst_scan_disable);
        end
        vectors++;
        if ({global_shift_enable, ctu_tst_short_chain, ctl.scan_capture,
             ctl.scan_busy, ctl.scan_done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b%b%b%b%b exp=00000", global_shift_enable,
                     ctu_tst_short_chain, ctl.scan_capture, ctl.scan_busy, ctl.scan_done);
        end
        vectors++;
        if (ctl.scan_sig !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset_sig got=%h exp=ffff", ctl.scan_sig);
        end
    endtask

    task automatic test_single_shift();
        so_0 = 1'b0;
        start_pass(16'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if (global_shift_enable !== (k == 2)) begin
                miscompares++;
                $display("FAIL single_gse t+%0d got=%b exp=%b", k, global_shift_enable, k == 2);
            end
            vectors++;
            if (ctl.scan_done !== (k == 4)) begin
                miscompares++;
                $display("FAIL single_done t+%0d got=%b exp=%b", k, ctl.scan_done, k == 4);
            end
            vectors++;
            if (ctl.scan_busy !== (k <= 4)) begin
                miscompares++;
                $display("FAIL single_busy t+%0d got=%b exp=%b", k, ctl.scan_busy, k <= 4);
            end
            vectors++;
            if (ctu_tst_short_chain !== 1'b0) begin
                miscompares++;
                $display("FAIL single_short t+%0d got=%b exp=0", k, ctu_tst_short_chain);
            end
            tick();
        end
        vectors++;
        if (ctl.scan_sig !== 16'hEFDF) begin
            miscompares++;
            $display("FAIL single_sig got=%h exp=efdf", ctl.scan_sig);
        end
    endtask

    task automatic test_long_capture();
        so_0 = 1'b1;
        start_pass(16'd5, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            vectors++;
            if (global_shift_enable !== (k >= 2 && k <= 6)) begin
                miscompares++;
                $display("FAIL long_gse t+%0d got=%b exp=%b", k, global_shift_enable,
                         k >= 2 && k <= 6);
            end
            vectors++;
            if (ctl.scan_capture !== (k == 8)) begin
                miscompares++;
                $display("FAIL long_capture t+%0d got=%b exp=%b", k, ctl.scan_capture, k == 8);
            end
            vectors++;
            if (ctl.scan_done !== (k == 9)) begin
                miscompares++;
                $display("FAIL long_done t+%0d got=%b exp=%b", k, ctl.scan_done, k == 9);
            end
            vectors++;
            if (ctl.scan_busy !== (k <= 9)) begin
                miscompares++;
                $display("FAIL long_busy t+%0d got=%b exp=%b", k, ctl.scan_busy, k <= 9);
            end
            vectors++;
            if (ctu_tst_short_chain !== 1'b1) begin
                miscompares++;
                $display("FAIL long_short t+%0d got=%b exp=1", k, ctu_tst_short_chain);
            end
            tick();
        end
        vectors++;
        if (ctl.scan_sig !== 16'hFFE0) begin
            miscompares++;
            $display("FAIL long_sig got=%h exp=ffe0", ctl.scan_sig);
        end
    endtask

    task automatic test_zero_length();
        so_0 = 1'b0;
        start_pass(16'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if (global_shift_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_gse t+%0d got=%b exp=0", k, global_shift_enable);
            end
            vectors++;
            if (ctl.scan_capture !== (k == 3)) begin
                miscompares++;
                $display("FAIL zero_capture t+%0d got=%b exp=%b", k, ctl.scan_capture, k == 3);
            end
            vectors++;
            if (ctl.scan_done !== (k == 4)) begin
                miscompares++;
                $display("FAIL zero_done t+%0d got=%b exp=%b", k, ctl.scan_done, k == 4);
            end
            vectors++;
            if (ctl.scan_busy !== (k <= 4)) begin
                miscompares++;
                $display("FAIL zero_busy t+%0d got=%b exp=%b", k, ctl.scan_busy, k <= 4);
            end
            tick();
        end
        vectors++;
        if (ctl.scan_sig !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL zero_sig got=%h exp=ffff", ctl.scan_sig);
        end
    endtask

    // Two samples (FFFF->EFDF->CF9F) are taken before the abort edge; the abort edge takes none.
    task automatic test_abort();
        so_0 = 1'b0;
        start_pass(16'd10, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            vectors++;
            if (global_shift_enable !== (k >= 2 && k <= 4)) begin
                miscompares++;
                $display("FAIL abort_gse t+%0d got=%b exp=%b", k, global_shift_enable,
                         k >= 2 && k <= 4);
            end
            vectors++;
            if (ctl.scan_busy !== (k <= 4)) begin
                miscompares++;
                $display("FAIL abort_busy t+%0d got=%b exp=%b", k, ctl.scan_busy, k <= 4);
            end
            vectors++;
            if (ctl.scan_done !== 1'b0 || ctl.scan_capture !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_done_cap t+%0d got=%b%b exp=00", k, ctl.scan_done,
                         ctl.scan_capture);
            end
            if (k >= 5) begin
                vectors++;
                if (ctl.scan_sig !== 16'hCF9F) begin
                    miscompares++;
                    $display("FAIL abort_sig t+%0d got=%h exp=cf9f", k, ctl.scan_sig);
                end
            end
            ctl.scan_abort = (k == 4);
            tick();
        end
        ctl.scan_abort = 1'b0;
    endtask

    task automatic test_ignored_start();
        so_0 = 1'b1;
        start_pass(16'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if (global_shift_enable !== (k >= 2 && k <= 3)) begin
                miscompares++;
                $display("FAIL ignored_gse t+%0d got=%b exp=%b", k, global_shift_enable,
                         k >= 2 && k <= 3);
            end
            vectors++;
            if (ctl.scan_done !== (k == 5)) begin
                miscompares++;
                $display("FAIL ignored_done t+%0d got=%b exp=%b", k, ctl.scan_done, k == 5);
            end
            vectors++;
            if (ctl.scan_busy !== (k <= 5)) begin
                miscompares++;
                $display("FAIL ignored_busy t+%0d got=%b exp=%b", k, ctl.scan_busy, k <= 5);
            end
            ctl.scan_start = (k == 3);
            ctl.scan_len   = (k == 3) ? 16'd7 : 16'd2;
            tick();
        end
        ctl.scan_start = 1'b0;
        vectors++;
        if (ctl.scan_sig !== 16'hFFFC) begin
            miscompares++;
            $display("FAIL ignored_sig got=%h exp=fffc", ctl.scan_sig);
        end
    endtask

    task automatic test_blocked_start();
        tst_scan_disable_req = 1'b1;
        tick();
        vectors++;
        if (ctu_tst_scan_disable !== 1'b1) begin
            miscompares++;
            $display("FAIL blocked_disable got=%b exp=1", ctu_tst_scan_disable);
        end
        start_pass(16'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if (ctl.scan_busy !== 1'b0 || global_shift_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL blocked_busy t+%0d got=%b%b exp=00", k, ctl.scan_busy,
                         global_shift_enable);
            end
            tick();
        end
        tst_scan_disable_req = 1'b0;
        tick();
        ctl.scan_abort = 1'b1;
        start_pass(16'd1, 1'b1, 1'b0);
        ctl.scan_abort = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if (ctl.scan_busy !== 1'b0 || global_shift_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL start_abort_busy t+%0d got=%b%b exp=00", k, ctl.scan_busy,
                         global_shift_enable);
            end
            tick();
        end
        vectors++;
        if (ctu_tst_short_chain !== 1'b0) begin
            miscompares++;
            $display("FAIL blocked_short got=%b exp=0", ctu_tst_short_chain);
        end
    endtask

    task automatic test_reset_mid_pass();
        so_0 = 1'b1;
        start_pass(16'd10, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({global_shift_enable, ctu_tst_scan_disable, ctu_tst_short_chain,
             ctl.scan_capture, ctl.scan_busy, ctl.scan_done} !== 6'b010000) begin
            miscompares++;
            $display("FAIL midreset_outputs got=%b%b%b%b%b%b exp=010000", global_shift_enable,
                     ctu_tst_scan_disable, ctu_tst_short_chain, ctl.scan_capture,
                     ctl.scan_busy, ctl.scan_done);
        end
        vectors++;
        if (ctl.scan_sig !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL midreset_sig got=%h exp=ffff", ctl.scan_sig);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst                 = 1'b1;
        so_0                = 1'b0;
        ctl.scan_start      = 1'b0;
        ctl.scan_abort      = 1'b0;
        ctl.scan_len        = 16'd0;
        ctl.scan_short      = 1'b0;
        ctl.scan_capture_en = 1'b0;
        tst_scan_disable_req = 1'b0;
        test_reset();
        test_single_shift();
        test_long_capture();
        test_zero_length();
        test_abort();
        test_ignored_start();
        test_blocked_start();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
